// File: rtl/ula_cmd_seq.sv
// ula_cmd_seq: clocked command front end for the combinational `ula` ALU.
// Accepts ops on a valid/ready port and returns result, zero and error on a second one.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_a, cmd_b operands, cmd_mode op select
//   ula_a/b/mode        registered operands and mode driven into `ula`
//   ula_result          combinational result returned by `ula`
//   rsp_valid/ready     response handshake; rsp_result, rsp_zero, rsp_err payload
//   op_count            successful responses consumed (wraps)
module ula_cmd_seq #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_mode,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [3:0]       ula_mode,
  input  logic [WIDTH-1:0] ula_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  // A zero settle time would sample ula_result in the same edge the
  // operands are launched, before the ALU has seen them.
  generate
    if (SETTLE < 1) begin : g_bad_settle
      $error("ula_cmd_seq: SETTLE must be >= 1");
    end
  endgenerate

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] CNT_INIT = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] cnt;
  logic          mode_ok;

  assign mode_ok = (cmd_mode < 4'd4);

  // Handshake outputs decode from the state register only.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_mode   <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (mode_ok) begin
              ula_a    <= cmd_a;
              ula_b    <= cmd_b;
              ula_mode <= cmd_mode;
              cnt      <= CNT_INIT;
              state    <= WAIT;
            end else begin
              // Unsupported op never reaches the ALU.
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_err    <= 1'b1;
              state      <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_result <= ula_result;
            rsp_zero   <= (ula_result == '0);
            rsp_err    <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
            if (!rsp_err) begin
              op_count <= op_count + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_cmd_seq.sv
// Bench for ula_cmd_seq: three instances (SETTLE=1,3,4) each with an ALU stand-in.
// Scoreboard queue of expected responses, popped when a response appears.
module tb_ula_cmd_seq;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst       [3];
  logic       cmd_valid [3];
  logic       cmd_ready [3];
  logic [7:0] cmd_a     [3];
  logic [7:0] cmd_b     [3];
  logic [3:0] cmd_mode  [3];
  logic [7:0] ula_a     [3];
  logic [7:0] ula_b     [3];
  logic [3:0] ula_mode  [3];
  logic [7:0] ula_result[3];
  logic       rsp_valid [3];
  logic       rsp_ready [3];
  logic [7:0] rsp_result[3];
  logic       rsp_zero  [3];
  logic       rsp_err   [3];
  logic [7:0] op_count  [3];

  exp_t       sb[$];
  logic [7:0] cnt_m    [3];
  logic [3:0] last_mode[3];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] m);
    case (m)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  assign ula_result[0] = alu(ula_a[0], ula_b[0], ula_mode[0]);
  assign ula_result[1] = alu(ula_a[1], ula_b[1], ula_mode[1]);
  assign ula_result[2] = alu(ula_a[2], ula_b[2], ula_mode[2]);

  ula_cmd_seq #(.WIDTH(8), .SETTLE(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_mode(cmd_mode[0]),
    .ula_a(ula_a[0]), .ula_b(ula_b[0]), .ula_mode(ula_mode[0]),
    .ula_result(ula_result[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_result(rsp_result[0]), .rsp_zero(rsp_zero[0]), .rsp_err(rsp_err[0]),
    .op_count(op_count[0]));

  ula_cmd_seq #(.WIDTH(8), .SETTLE(3), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_mode(cmd_mode[1]),
    .ula_a(ula_a[1]), .ula_b(ula_b[1]), .ula_mode(ula_mode[1]),
    .ula_result(ula_result[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_result(rsp_result[1]), .rsp_zero(rsp_zero[1]), .rsp_err(rsp_err[1]),
    .op_count(op_count[1]));

  ula_cmd_seq #(.WIDTH(8), .SETTLE(4), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_a(cmd_a[2]), .cmd_b(cmd_b[2]), .cmd_mode(cmd_mode[2]),
    .ula_a(ula_a[2]), .ula_b(ula_b[2]), .ula_mode(ula_mode[2]),
    .ula_result(ula_result[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_result(rsp_result[2]), .rsp_zero(rsp_zero[2]), .rsp_err(rsp_err[2]),
    .op_count(op_count[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    exp_t e;
    if (m < 4'd4) begin
      e.r = alu(a, b, m);
      e.z = (e.r == 8'h00);
      e.e = 1'b0;
    end else begin
      e.r = 8'h00;
      e.z = 1'b0;
      e.e = 1'b1;
    end
    sb.push_back(e);
  endtask

  // Called #1 after the accept edge. lat = edges after the accept edge
  // until rsp_valid is seen; hold = cycles of backpressure before ready.
  task automatic finish_rsp(input int k, input int lat, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!rsp_valid[k] && n < 40) begin
      total++;
      if (cmd_ready[k] !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready k=%0d got=%b exp=0", k, cmd_ready[k]);
      end
      step();
      n++;
    end
    total++;
    if (rsp_valid[k] !== 1'b1 || n != lat) begin
      bad++;
      $display("FAIL latency k=%0d got=%0d valid=%b exp=%0d", k, n, rsp_valid[k], lat);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty k=%0d got=0 exp>=1", k);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    total++;
    if (rsp_result[k] !== e.r) begin
      bad++;
      $display("FAIL result k=%0d got=%0d exp=%0d", k, rsp_result[k], e.r);
    end
    total++;
    if (rsp_zero[k] !== e.z) begin
      bad++;
      $display("FAIL zero k=%0d got=%b exp=%b", k, rsp_zero[k], e.z);
    end
    total++;
    if (rsp_err[k] !== e.e) begin
      bad++;
      $display("FAIL err k=%0d got=%b exp=%b", k, rsp_err[k], e.e);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      total++;
      if (rsp_valid[k] !== 1'b1 || cmd_ready[k] !== 1'b0 ||
          rsp_result[k] !== e.r || rsp_zero[k] !== e.z || rsp_err[k] !== e.e) begin
        bad++;
        $display("FAIL hold k=%0d got=%b%b/%0d/%b%b exp=10/%0d/%b%b", k,
                 rsp_valid[k], cmd_ready[k], rsp_result[k], rsp_zero[k], rsp_err[k],
                 e.r, e.z, e.e);
      end
    end
    rsp_ready[k] = 1'b1;
    step();
    rsp_ready[k] = 1'b0;
    if (!e.e) cnt_m[k] = cnt_m[k] + 8'd1;
    total++;
    if (rsp_valid[k] !== 1'b0 || cmd_ready[k] !== 1'b1) begin
      bad++;
      $display("FAIL release k=%0d got=%b%b exp=01", k, rsp_valid[k], cmd_ready[k]);
    end
    total++;
    if (op_count[k] !== cnt_m[k]) begin
      bad++;
      $display("FAIL op_count k=%0d got=%0d exp=%0d", k, op_count[k], cnt_m[k]);
    end
  endtask

  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] m, input int hold);
    push_exp(a, b, m);
    total++;
    if (cmd_ready[k] !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready k=%0d got=%b exp=1", k, cmd_ready[k]);
    end
    cmd_a[k] = a;
    cmd_b[k] = b;
    cmd_mode[k] = m;
    cmd_valid[k] = 1'b1;
    step();
    cmd_valid[k] = 1'b0;
    if (m < 4'd4) last_mode[k] = m;
    total++;
    if ((m < 4'd4 && (ula_a[k] !== a || ula_b[k] !== b)) || ula_mode[k] !== last_mode[k]) begin
      bad++;
      $display("FAIL ula_drive k=%0d got=%0d,%0d,%0d exp_mode=%0d", k,
               ula_a[k], ula_b[k], ula_mode[k], last_mode[k]);
    end
    finish_rsp(k, (m < 4'd4) ? settle_of(k) : 0, hold);
  endtask

  task automatic check_clear(input int k, input string tag);
    total++;
    if (cmd_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || ula_a[k] !== 8'd0 ||
        ula_b[k] !== 8'd0 || ula_mode[k] !== 4'd0 || op_count[k] !== 8'd0 ||
        rsp_result[k] !== 8'd0 || rsp_zero[k] !== 1'b0 || rsp_err[k] !== 1'b0) begin
      bad++;
      $display("FAIL %s k=%0d got=rdy%b vld%b a%0d b%0d m%0d cnt%0d r%0d z%b e%b exp=all_clear",
               tag, k, cmd_ready[k], rsp_valid[k], ula_a[k], ula_b[k], ula_mode[k],
               op_count[k], rsp_result[k], rsp_zero[k], rsp_err[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cnt_m[k] = 8'd0;
      last_mode[k] = 4'd0;
      check_clear(k, "reset");
    end
  endtask

  task automatic test_add();
    run_op(0, 8'd86, 8'd107, 4'd0, 0);
  endtask

  task automatic test_sub();
    run_op(0, 8'd107, 8'd107, 4'd1, 1);
    run_op(0, 8'd4, 8'd8, 4'd1, 0);
  endtask

  task automatic test_backpressure();
    push_exp(8'hAA, 8'h55, 4'd2);
    cmd_a[1] = 8'hAA;
    cmd_b[1] = 8'h55;
    cmd_mode[1] = 4'd2;
    cmd_valid[1] = 1'b1;
    step();
    last_mode[1] = 4'd2;
    // Second command held on the port for the whole busy window.
    cmd_a[1] = 8'h0F;
    cmd_b[1] = 8'hF0;
    cmd_mode[1] = 4'd3;
    total++;
    if (ula_a[1] !== 8'hAA || ula_mode[1] !== 4'd2) begin
      bad++;
      $display("FAIL bp_drive got=%0h,%0d exp=aa,2", ula_a[1], ula_mode[1]);
    end
    finish_rsp(1, 3, 5);
    push_exp(8'h0F, 8'hF0, 4'd3);
    step();
    cmd_valid[1] = 1'b0;
    last_mode[1] = 4'd3;
    total++;
    if (ula_a[1] !== 8'h0F || ula_b[1] !== 8'hF0 || cmd_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL bp_held_cmd got=%0h,%0h,rdy%b exp=0f,f0,rdy0",
               ula_a[1], ula_b[1], cmd_ready[1]);
    end
    finish_rsp(1, 3, 0);
  endtask

  task automatic test_error();
    run_op(0, 8'hAA, 8'h00, 4'd3, 0);
    run_op(0, 8'h11, 8'h22, 4'd5, 2);
    run_op(1, 8'h12, 8'h34, 4'd15, 1);
    run_op(1, 8'hC8, 8'h64, 4'd0, 0);
  endtask

  task automatic test_reset_mid_op();
    run_op(2, 8'd3, 8'd5, 4'd2, 0);
    cmd_a[2] = 8'd9;
    cmd_b[2] = 8'd3;
    cmd_mode[2] = 4'd0;
    cmd_valid[2] = 1'b1;
    step();
    cmd_valid[2] = 1'b0;
    step();
    step();
    rst[2] = 1'b1;
    cmd_valid[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    cmd_valid[2] = 1'b0;
    cnt_m[2] = 8'd0;
    last_mode[2] = 4'd0;
    check_clear(2, "mid_reset");
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (rsp_valid[2] !== 1'b0) begin
        bad++;
        $display("FAIL ghost_rsp cyc=%0d got=%b exp=0", i, rsp_valid[2]);
      end
    end
    run_op(2, 8'd200, 8'd100, 4'd0, 0);
  endtask

  task automatic test_wrap();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    cnt_m[0] = 8'd0;
    last_mode[0] = 4'd0;
    for (int i = 0; i < 256; i++) begin
      run_op(0, 8'($urandom), 8'($urandom), 4'($urandom_range(3, 0)), 0);
    end
    total++;
    if (op_count[0] !== 8'd0) begin
      bad++;
      $display("FAIL wrap got=%0d exp=0", op_count[0]);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      cmd_valid[k] = 1'b0;
      cmd_a[k] = 8'd0;
      cmd_b[k] = 8'd0;
      cmd_mode[k] = 4'd0;
      rsp_ready[k] = 1'b0;
      cnt_m[k] = 8'd0;
      last_mode[k] = 4'd0;
    end
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_error();
    test_reset_mid_op();
    test_wrap();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
